// File: rtl/mux_4_1_rr_arbiter_if.sv
// Request/data bundle between four requesters and the 4:1 round-robin arbiter.
// master: requester side (drives req and lane data, observes grant and routed data)
// slave:  arbiter side (samples req and lane data, drives gnt, S, busy and Y)
interface mux_4_1_rr_arbiter_if #(
   parameter int WIDTH = 1
);
   logic [3:0]         req;
   logic [4*WIDTH-1:0] I;
   logic [3:0]         gnt;
   logic [1:0]         S;
   logic               busy;
   logic [WIDTH-1:0]   Y;

   modport master (
      output req,
      output I,
      input  gnt,
      input  S,
      input  busy,
      input  Y
   );

   modport slave (
      input  req,
      input  I,
      output gnt,
      output S,
      output busy,
      output Y
   );
endinterface

// File: rtl/mux_4_1_rr_arbiter.sv
// Round-robin arbiter and select controller for a shared 4:1 multiplexer.
// Four requesters compete for one output lane. The winner gets a registered
// one-hot grant and mux select, and its lane data is routed combinationally to Y.
// The search for a winner starts at a rotating pointer that moves to one past
// each new winner, so simultaneous requests are served in turn.
// Optional feature macro: ARB_TIMEOUT_EN. When defined, an owner that has held
// the lane for MAX_HOLD cycles is preempted if another requester is waiting.
// Without it an owner keeps the lane until its own req drops.
module mux_4_1_rr_arbiter #(
   parameter int WIDTH    = 1,
   parameter int MAX_HOLD = 8
) (
   input logic                 clk,
   input logic                 rst,
   mux_4_1_rr_arbiter_if.slave bus
);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   // The hold limit is kept to a range the 8-bit saturating counter can reach.
   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("mux_4_1_rr_arbiter: MAX_HOLD must be in 2..255");
   end

   state_t     state;
   logic [3:0] gnt_q;
   logic [1:0] sel_q;
   logic       busy_q;
   logic [1:0] ptr;

   logic [3:0] cand_mask;
   logic [2:0] cand_pick;
   logic       cand_found;
   logic [1:0] cand_idx;
   logic       owner_req;
   logic       take_grant;
   logic       go_idle;
   logic       preempt;

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
   logic [7:0] hold;
`endif

   // Returns {found, index} of the first set bit of mask, scanning from start
   // upward with wrap. Scanning backwards lets the closest position win last.
   function automatic logic [2:0] rr_pick(input logic [3:0] mask,
                                          input logic [1:0] start);
      logic [2:0] result;
      logic [1:0] idx;
      result = 3'b000;
      for (int k = 3; k >= 0; k--) begin
         idx = start + 2'(k);
         if (mask[idx]) begin
            result = {1'b1, idx};
         end
      end
      return result;
   endfunction

   // Candidate search: every requester except the current owner competes from ptr.
   // When idle gnt_q is zero, so all requests compete.
   always_comb begin
      cand_mask  = bus.req & ~gnt_q;
      cand_pick  = rr_pick(cand_mask, ptr);
      cand_found = cand_pick[2];
      cand_idx   = cand_pick[1:0];
      owner_req  = bus.req[sel_q];
   end

   // Decide whether this edge hands out a new grant or returns to idle.
   always_comb begin
      preempt = 1'b0;
`ifdef ARB_TIMEOUT_EN
      preempt = owner_req && (hold >= HOLD_LIMIT);
`endif
      take_grant = 1'b0;
      go_idle    = 1'b0;
      case (state)
         IDLE: begin
            take_grant = cand_found;
         end
         GRANT: begin
            take_grant = cand_found && (!owner_req || preempt);
            go_idle    = !owner_req && !cand_found;
         end
         default: begin
            go_idle = 1'b1;
         end
      endcase
   end

   // Arbiter state machine: all outputs and the rotation pointer are registered here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         gnt_q  <= 4'b0000;
         sel_q  <= 2'b00;
         busy_q <= 1'b0;
         ptr    <= 2'd0;
`ifdef ARB_TIMEOUT_EN
         hold   <= 8'd0;
`endif
      end else if (take_grant) begin
         state  <= GRANT;
         gnt_q  <= 4'b0001 << cand_idx;
         sel_q  <= cand_idx;
         busy_q <= 1'b1;
         ptr    <= cand_idx + 2'd1;
`ifdef ARB_TIMEOUT_EN
         hold   <= 8'd1;
`endif
      end else if (go_idle) begin
         state  <= IDLE;
         gnt_q  <= 4'b0000;
         busy_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         hold   <= 8'd0;
`endif
      end else begin
`ifdef ARB_TIMEOUT_EN
         if (state == GRANT && hold != 8'hFF) begin
            hold <= hold + 8'd1;
         end
`endif
      end
   end

   // Output lane mux: the selected lane passes straight through while busy.
   always_comb begin
      bus.Y = '0;
      for (int i = 0; i < 4; i++) begin
         if (busy_q && sel_q == 2'(i)) begin
            bus.Y = bus.I[i*WIDTH +: WIDTH];
         end
      end
   end

   assign bus.gnt  = gnt_q;
   assign bus.S    = sel_q;
   assign bus.busy = busy_q;

   // Structural invariants of the grant outputs.
   a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst)
      $onehot0(gnt_q));
   a_gnt_matches_sel : assert property (@(posedge clk) disable iff (rst)
      busy_q |-> gnt_q[sel_q]);
   a_busy_matches_gnt : assert property (@(posedge clk) disable iff (rst)
      busy_q == (gnt_q != 4'b0000));

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Self-checking bench for mux_4_1_rr_arbiter (WIDTH=8, MAX_HOLD=4).
// Each scenario task pushes the expected outputs into a scoreboard queue as it
// drives stimulus and pops/compares them once the DUT has responded.
// Expectations for the hold-limit scenario follow ARB_TIMEOUT_EN.
module tb_mux_4_1_rr_arbiter;

   localparam int WIDTH    = 8;
   localparam int MAX_HOLD = 4;

   typedef struct {
      logic [3:0]       gnt;
      logic [1:0]       s;
      logic             busy;
      logic [WIDTH-1:0] y;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   logic [4*WIDTH-1:0] lanes;

   mux_4_1_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

   mux_4_1_rr_arbiter #(
      .WIDTH   (WIDTH),
      .MAX_HOLD(MAX_HOLD)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Bench-side lane data for a given select value.
   function automatic logic [WIDTH-1:0] lane_of(input logic [1:0] s);
      return lanes[s*WIDTH +: WIDTH];
   endfunction

   // Synchronous-looking reset pulse placed between edges; leaves req idle.
   task automatic apply_reset();
      @(negedge clk);
      rst     = 1'b1;
      bus.req = 4'b0000;
      @(negedge clk);
      rst     = 1'b0;
   endtask

   // Reset values appear immediately and hold through an edge with requests pending.
   task automatic test_reset();
      exp_t e;
      rst     = 1'b1;
      bus.req = 4'b0000;
      bus.I   = lanes;
      exp_q.push_back('{gnt: 4'b0000, s: 2'd0, busy: 1'b0, y: '0});
      #2;
      e = exp_q.pop_front();
      checks++;
      if (bus.gnt !== e.gnt || bus.S !== e.s || bus.busy !== e.busy || bus.Y !== e.y) begin
         errors++;
         $display("[TB] FAIL reset_immediate: gnt=%b S=%b busy=%b Y=%h, expected gnt=%b S=%b busy=%b Y=%h",
                  bus.gnt, bus.S, bus.busy, bus.Y, e.gnt, e.s, e.busy, e.y);
      end
      bus.req = 4'b1111;
      exp_q.push_back('{gnt: 4'b0000, s: 2'd0, busy: 1'b0, y: '0});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (bus.gnt !== e.gnt || bus.S !== e.s || bus.busy !== e.busy || bus.Y !== e.y) begin
         errors++;
         $display("[TB] FAIL reset_held: gnt=%b S=%b busy=%b Y=%h, expected gnt=%b S=%b busy=%b Y=%h",
                  bus.gnt, bus.S, bus.busy, bus.Y, e.gnt, e.s, e.busy, e.y);
      end
      bus.req = 4'b0000;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One requester: grant after one clock, release leaves S on the last owner.
   task automatic test_single_request();
      logic [3:0] reqs  [3];
      logic [3:0] gnts  [3];
      logic [1:0] sels  [3];
      logic       busys [3];
      exp_t       e;
      reqs  = '{4'b0100, 4'b0000, 4'b0000};
      gnts  = '{4'b0100, 4'b0000, 4'b0000};
      sels  = '{2'd2, 2'd2, 2'd2};
      busys = '{1'b1, 1'b0, 1'b0};
      apply_reset();
      for (int k = 0; k < 3; k++) begin
         bus.req = reqs[k];
         e.gnt  = gnts[k];
         e.s    = sels[k];
         e.busy = busys[k];
         e.y    = busys[k] ? lane_of(sels[k]) : '0;
         exp_q.push_back(e);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (bus.gnt !== e.gnt || bus.S !== e.s || bus.busy !== e.busy || bus.Y !== e.y) begin
            errors++;
            $display("[TB] FAIL single_request step %0d: gnt=%b S=%b busy=%b Y=%h, expected gnt=%b S=%b busy=%b Y=%h",
                     k, bus.gnt, bus.S, bus.busy, bus.Y, e.gnt, e.s, e.busy, e.y);
         end
      end
   endtask

   // All four requesting; each owner drops for one cycle, order must rotate 0,1,2,3,0.
   task automatic test_rotation();
      logic [3:0] reqs  [6];
      logic [3:0] gnts  [6];
      logic [1:0] sels  [6];
      logic       busys [6];
      exp_t       e;
      reqs  = '{4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b0000};
      gnts  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000};
      sels  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
      busys = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      apply_reset();
      for (int k = 0; k < 6; k++) begin
         bus.req = reqs[k];
         e.gnt  = gnts[k];
         e.s    = sels[k];
         e.busy = busys[k];
         e.y    = busys[k] ? lane_of(sels[k]) : '0;
         exp_q.push_back(e);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (bus.gnt !== e.gnt || bus.S !== e.s || bus.busy !== e.busy || bus.Y !== e.y) begin
            errors++;
            $display("[TB] FAIL rotation step %0d: gnt=%b S=%b busy=%b Y=%h, expected gnt=%b S=%b busy=%b Y=%h",
                     k, bus.gnt, bus.S, bus.busy, bus.Y, e.gnt, e.s, e.busy, e.y);
         end
      end
   endtask

   // Owner 1 drops with requester 3 waiting: handoff on the same edge, no idle cycle.
   task automatic test_back_to_back();
      logic [3:0] reqs  [4];
      logic [3:0] gnts  [4];
      logic [1:0] sels  [4];
      logic       busys [4];
      exp_t       e;
      reqs  = '{4'b1010, 4'b1000, 4'b1000, 4'b0000};
      gnts  = '{4'b0010, 4'b1000, 4'b1000, 4'b0000};
      sels  = '{2'd1, 2'd3, 2'd3, 2'd3};
      busys = '{1'b1, 1'b1, 1'b1, 1'b0};
      apply_reset();
      for (int k = 0; k < 4; k++) begin
         bus.req = reqs[k];
         e.gnt  = gnts[k];
         e.s    = sels[k];
         e.busy = busys[k];
         e.y    = busys[k] ? lane_of(sels[k]) : '0;
         exp_q.push_back(e);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (bus.gnt !== e.gnt || bus.S !== e.s || bus.busy !== e.busy || bus.Y !== e.y) begin
            errors++;
            $display("[TB] FAIL back_to_back step %0d: gnt=%b S=%b busy=%b Y=%h, expected gnt=%b S=%b busy=%b Y=%h",
                     k, bus.gnt, bus.S, bus.busy, bus.Y, e.gnt, e.s, e.busy, e.y);
         end
      end
   endtask

   // Reset between edges while owner 3 holds; after release the search restarts at 0.
   task automatic test_async_reset();
      exp_t e;
      apply_reset();
      bus.req = 4'b1000;
      exp_q.push_back('{gnt: 4'b1000, s: 2'd3, busy: 1'b1, y: lane_of(2'd3)});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (bus.gnt !== e.gnt || bus.S !== e.s || bus.busy !== e.busy || bus.Y !== e.y) begin
         errors++;
         $display("[TB] FAIL async_reset_grant3: gnt=%b S=%b busy=%b Y=%h, expected gnt=%b S=%b busy=%b Y=%h",
                  bus.gnt, bus.S, bus.busy, bus.Y, e.gnt, e.s, e.busy, e.y);
      end
      #2;
      rst     = 1'b1;
      bus.req = 4'b1001;
      exp_q.push_back('{gnt: 4'b0000, s: 2'd0, busy: 1'b0, y: '0});
      #1;
      e = exp_q.pop_front();
      checks++;
      if (bus.gnt !== e.gnt || bus.S !== e.s || bus.busy !== e.busy || bus.Y !== e.y) begin
         errors++;
         $display("[TB] FAIL async_reset_midcycle: gnt=%b S=%b busy=%b Y=%h, expected gnt=%b S=%b busy=%b Y=%h",
                  bus.gnt, bus.S, bus.busy, bus.Y, e.gnt, e.s, e.busy, e.y);
      end
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back('{gnt: 4'b0001, s: 2'd0, busy: 1'b1, y: lane_of(2'd0)});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (bus.gnt !== e.gnt || bus.S !== e.s || bus.busy !== e.busy || bus.Y !== e.y) begin
         errors++;
         $display("[TB] FAIL async_reset_release: gnt=%b S=%b busy=%b Y=%h, expected gnt=%b S=%b busy=%b Y=%h",
                  bus.gnt, bus.S, bus.busy, bus.Y, e.gnt, e.s, e.busy, e.y);
      end
      // Pointer now sits at 1; a reset must bring it back to 0.
      @(negedge clk);
      rst     = 1'b1;
      bus.req = 4'b0011;
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back('{gnt: 4'b0001, s: 2'd0, busy: 1'b1, y: lane_of(2'd0)});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (bus.gnt !== e.gnt || bus.S !== e.s || bus.busy !== e.busy || bus.Y !== e.y) begin
         errors++;
         $display("[TB] FAIL async_reset_ptr_cleared: gnt=%b S=%b busy=%b Y=%h, expected gnt=%b S=%b busy=%b Y=%h",
                  bus.gnt, bus.S, bus.busy, bus.Y, e.gnt, e.s, e.busy, e.y);
      end
      bus.req = 4'b0000;
   endtask

   // Lane 2 routed to Y; data changes pass through without a clock; idle forces zero.
   task automatic test_data_routing();
      logic [WIDTH-1:0] ys    [4];
      logic [3:0]       gnts  [4];
      logic             busys [4];
      logic             clocked [4];
      logic [WIDTH-1:0] lane2 [4];
      logic [3:0]       reqs  [4];
      exp_t             e;
      reqs    = '{4'b0100, 4'b0100, 4'b0000, 4'b0000};
      lane2   = '{8'hC3, 8'h5A, 8'h5A, 8'h77};
      clocked = '{1'b1, 1'b0, 1'b1, 1'b0};
      gnts    = '{4'b0100, 4'b0100, 4'b0000, 4'b0000};
      busys   = '{1'b1, 1'b1, 1'b0, 1'b0};
      ys      = '{8'hC3, 8'h5A, 8'h00, 8'h00};
      apply_reset();
      for (int k = 0; k < 4; k++) begin
         bus.req = reqs[k];
         lanes[2*WIDTH +: WIDTH] = lane2[k];
         bus.I = lanes;
         exp_q.push_back('{gnt: gnts[k], s: 2'd2, busy: busys[k], y: ys[k]});
         if (clocked[k]) begin
            @(posedge clk);
         end
         #1;
         e = exp_q.pop_front();
         checks++;
         if (bus.gnt !== e.gnt || bus.S !== e.s || bus.busy !== e.busy || bus.Y !== e.y) begin
            errors++;
            $display("[TB] FAIL data_routing step %0d: gnt=%b S=%b busy=%b Y=%h, expected gnt=%b S=%b busy=%b Y=%h",
                     k, bus.gnt, bus.S, bus.busy, bus.Y, e.gnt, e.s, e.busy, e.y);
         end
      end
      lanes = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
      bus.I = lanes;
   endtask

   // Two requesters held constantly: rotation every MAX_HOLD cycles only with the timeout.
   task automatic test_hold_limit();
      exp_t e;
      logic [1:0] owner;
      apply_reset();
      bus.req = 4'b0011;
      for (int k = 0; k < 3 * MAX_HOLD; k++) begin
`ifdef ARB_TIMEOUT_EN
         owner = ((k / MAX_HOLD) % 2 == 0) ? 2'd0 : 2'd1;
`else
         owner = 2'd0;
`endif
         exp_q.push_back('{gnt: 4'b0001 << owner, s: owner, busy: 1'b1, y: lane_of(owner)});
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (bus.gnt !== e.gnt || bus.S !== e.s || bus.busy !== e.busy || bus.Y !== e.y) begin
            errors++;
            $display("[TB] FAIL hold_limit cycle %0d: gnt=%b S=%b busy=%b Y=%h, expected gnt=%b S=%b busy=%b Y=%h",
                     k, bus.gnt, bus.S, bus.busy, bus.Y, e.gnt, e.s, e.busy, e.y);
         end
      end
      bus.req = 4'b0000;
   endtask

   // Scenario sequence and summary.
   initial begin
      lanes   = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
      bus.I   = lanes;
      bus.req = 4'b0000;
      test_reset();
      test_single_request();
      test_rotation();
      test_back_to_back();
      test_async_reset();
      test_data_routing();
      test_hold_limit();
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Run-time bound so the bench can never hang.
   initial begin
      #100000;
      errors++;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
